// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single BRAM controller port.
// Round-robin arbitration with optional burst locking. Grants are
// combinational so that one access is issued every cycle. Read data
// returned by the controller is routed back via a one-bit read tag.
module bram_arbiter #(
    parameter int DAT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m1_req,
    input  logic                  m0_lock,
    input  logic                  m1_lock,
    input  logic                  m0_wren,
    input  logic                  m1_wren,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DAT_WIDTH-1:0]  m0_idat,
    input  logic [DAT_WIDTH-1:0]  m1_idat,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic [DAT_WIDTH-1:0]  m0_odat,
    output logic [DAT_WIDTH-1:0]  m1_odat,
    output logic                  m0_oval,
    output logic                  m1_oval,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DAT_WIDTH-1:0]  bram_idat,
    output logic                  bram_wren,
    output logic                  bram_rden,
    input  logic [DAT_WIDTH-1:0]  bram_odat,
    input  logic                  bram_oval
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       last_r;     // index of the most recent ARB-state grant
    logic       rd_tag_r;   // owner of the read currently in flight
    logic       gnt0_s;
    logic       gnt1_s;
    logic       wren_s;
    logic       rden_s;

    // Grant decision: round-robin tie-break in ARB, exclusive owner in LOCKx
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                ST_ARB: begin
                    if (m0_req && m1_req) begin
                        // the requester that did not win last time wins the tie
                        gnt0_s = last_r;
                        gnt1_s = ~last_r;
                    end else begin
                        gnt0_s = m0_req;
                        gnt1_s = m1_req;
                    end
                end
                ST_LOCK0: gnt0_s = m0_req;
                ST_LOCK1: gnt1_s = m1_req;
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Next state: enter a lock on a locked grant, leave when the owner drops req or lock
    always_comb begin
        state_nxt_s = ST_ARB;
        case (state_r)
            ST_ARB: begin
                if (gnt0_s && m0_lock) begin
                    state_nxt_s = ST_LOCK0;
                end else if (gnt1_s && m1_lock) begin
                    state_nxt_s = ST_LOCK1;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_LOCK0: begin
                if (m0_req && m0_lock) begin
                    state_nxt_s = ST_LOCK0;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_LOCK1: begin
                if (m1_req && m1_lock) begin
                    state_nxt_s = ST_LOCK1;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            default: state_nxt_s = ST_ARB;
        endcase
    end

    // Outputs: mux the granted requester onto the BRAM port and route read data back
    always_comb begin
        bram_addr = m0_addr;
        bram_idat = m0_idat;
        wren_s    = 1'b0;
        rden_s    = 1'b0;
        if (gnt1_s) begin
            bram_addr = m1_addr;
            bram_idat = m1_idat;
            wren_s    = m1_wren;
            rden_s    = ~m1_wren;
        end else if (gnt0_s) begin
            bram_addr = m0_addr;
            bram_idat = m0_idat;
            wren_s    = m0_wren;
            rden_s    = ~m0_wren;
        end else begin
            bram_addr = m0_addr;
            bram_idat = m0_idat;
            wren_s    = 1'b0;
            rden_s    = 1'b0;
        end
        m0_gnt    = gnt0_s;
        m1_gnt    = gnt1_s;
        bram_wren = wren_s;
        bram_rden = rden_s;
        m0_odat   = bram_odat;
        m1_odat   = bram_odat;
        // a read in flight across reset is never reported
        m0_oval   = rst_n & bram_oval & ~rd_tag_r;
        m1_oval   = rst_n & bram_oval & rd_tag_r;
    end

    // State, round-robin pointer and read tag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_ARB;
            last_r   <= 1'b1;
            rd_tag_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            // the pointer is frozen while a burst owns the port
            if ((state_r == ST_ARB) && (gnt0_s || gnt1_s)) begin
                last_r <= gnt1_s;
            end else begin
                last_r <= last_r;
            end
            if (rden_s) begin
                rd_tag_r <= gnt1_s;
            end else begin
                rd_tag_r <= rd_tag_r;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_bram_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_v  [2];
    logic          lock_v [2];
    logic          wren_v [2];
    logic [AW-1:0] addr_v [2];
    logic [DW-1:0] idat_v [2];

    logic          m0_gnt, m1_gnt, m0_oval, m1_oval;
    logic [DW-1:0] m0_odat, m1_odat;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_idat;
    logic          bram_wren, bram_rden;
    logic [DW-1:0] bram_odat = 32'h0000_0000;
    logic          bram_oval = 1'b0;

    logic [DW-1:0] bram_mem [256];
    logic          mem_init_done = 1'b0;
    logic [DW-1:0] exp_mem  [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req_v[0]), .m1_req(req_v[1]),
        .m0_lock(lock_v[0]), .m1_lock(lock_v[1]),
        .m0_wren(wren_v[0]), .m1_wren(wren_v[1]),
        .m0_addr(addr_v[0]), .m1_addr(addr_v[1]),
        .m0_idat(idat_v[0]), .m1_idat(idat_v[1]),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_odat(m0_odat), .m1_odat(m1_odat),
        .m0_oval(m0_oval), .m1_oval(m1_oval),
        .bram_addr(bram_addr), .bram_idat(bram_idat),
        .bram_wren(bram_wren), .bram_rden(bram_rden),
        .bram_odat(bram_odat), .bram_oval(bram_oval)
    );

    // BRAM controller stand-in: write on wren, read data + valid one cycle after rden
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) bram_mem[i] <= 32'h5A00_0000 | i;
            mem_init_done <= 1'b1;
        end else begin
            bram_oval <= bram_rden;
            if (bram_rden) bram_odat <= bram_mem[bram_addr[7:0]];
            if (bram_wren) bram_mem[bram_addr[7:0]] <= bram_idat;
        end
    end

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            req_v[p]  = 1'b0;
            lock_v[p] = 1'b0;
            wren_v[p] = 1'b0;
            addr_v[p] = 32'($urandom_range(0, 255));
            idat_v[p] = $urandom;
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic l, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_v[p]  = r;
        lock_v[p] = l;
        wren_v[p] = w;
        addr_v[p] = a;
        idat_v[p] = d;
    endtask

    // all tasks start and finish 1 time unit after a rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        idle_inputs();
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++)
                set_port(p, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, bram_wren, bram_rden, m0_oval, m1_oval} !== 6'b000000) begin
                errors++;
                $display("FAIL reset_outputs_low cycle %0d: got %b want 000000", k,
                         {m0_gnt, m1_gnt, bram_wren, bram_rden, m0_oval, m1_oval});
            end
            next_cycle();
        end
        rst_n = 1'b1;
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h21, 32'h0);
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_tie_m0: got {m1,m0}=%b want 01", {m1_gnt, m0_gnt});
        end
        checks++;
        if (bram_rden !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_rden: got %b want 1", bram_rden);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int exp_g, prev_g;
        logic [7:0] prev_a;
        prev_g = -1;
        prev_a = 8'd0;
        apply_reset(2);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                for (int p = 0; p < 2; p++)
                    set_port(p, 1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 255)), $urandom);
            end else begin
                idle_inputs();
            end
            exp_g = (k < 4) ? (k % 2) : -1;
            @(negedge clk);
            checks++;
            if (m0_gnt !== (exp_g == 0) || m1_gnt !== (exp_g == 1)) begin
                errors++;
                $display("FAIL rr_grant cycle %0d: got {m1,m0}=%b%b want grant index %0d", k, m1_gnt, m0_gnt, exp_g);
            end
            if (k < 4) begin
                checks++;
                if (bram_rden !== 1'b1 || bram_addr !== addr_v[exp_g]) begin
                    errors++;
                    $display("FAIL rr_read_issue cycle %0d: got rden=%b addr=%h want rden=1 addr=%h",
                             k, bram_rden, bram_addr, addr_v[exp_g]);
                end
            end
            checks++;
            if (m0_oval !== (prev_g == 0) || m1_oval !== (prev_g == 1)) begin
                errors++;
                $display("FAIL rr_oval_route cycle %0d: got {m1,m0}=%b%b want owner %0d", k, m1_oval, m0_oval, prev_g);
            end
            if (prev_g >= 0) begin
                checks++;
                if (((prev_g == 0) ? m0_odat : m1_odat) !== exp_mem[prev_a]) begin
                    errors++;
                    $display("FAIL rr_odat cycle %0d: got %h want %h", k,
                             (prev_g == 0) ? m0_odat : m1_odat, exp_mem[prev_a]);
                end
            end
            if (exp_g >= 0) prev_a = addr_v[exp_g][7:0];
            prev_g = exp_g;
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        set_port(1, 1'b1, 1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5);
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b10 || bram_wren !== 1'b1 || bram_rden !== 1'b0) begin
            errors++;
            $display("FAIL wr_issue: got {m1,m0}=%b wren=%b rden=%b want 10 1 0", {m1_gnt, m0_gnt}, bram_wren, bram_rden);
        end
        checks++;
        if (bram_addr !== 32'h10 || bram_idat !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL wr_mux: got addr=%h idat=%h want 00000010 a5a5a5a5", bram_addr, bram_idat);
        end
        exp_mem[16] = 32'hA5A5_A5A5;
        next_cycle();
        idle_inputs();
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h10, $urandom);
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01 || bram_rden !== 1'b1 || bram_addr !== 32'h10) begin
            errors++;
            $display("FAIL rd_issue: got {m1,m0}=%b rden=%b addr=%h want 01 1 00000010", {m1_gnt, m0_gnt}, bram_rden, bram_addr);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_oval !== 1'b1 || m1_oval !== 1'b0 || m0_odat !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL rd_after_wr: got m0_oval=%b m1_oval=%b m0_odat=%h want 1 0 a5a5a5a5", m0_oval, m1_oval, m0_odat);
        end
        checks++;
        if (bram_addr !== addr_v[0] || bram_wren !== 1'b0 || bram_rden !== 1'b0) begin
            errors++;
            $display("FAIL idle_mux: got addr=%h wren=%b rden=%b want %h 0 0", bram_addr, bram_wren, bram_rden, addr_v[0]);
        end
        next_cycle();
    endtask

    task automatic test_lock_burst();
        logic [7:0] prev_a;
        int prev_g;
        prev_g = -1;
        prev_a = 8'd0;
        apply_reset(1);
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            if (k < 4) set_port(0, 1'b1, (k < 3), 1'b0, 32'($urandom_range(0, 255)), $urandom);
            if (k < 5) set_port(1, 1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 255)), $urandom);
            @(negedge clk);
            checks++;
            if ({m1_gnt, m0_gnt} !== ((k < 4) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00))) begin
                errors++;
                $display("FAIL lock_grant cycle %0d: got {m1,m0}=%b", k, {m1_gnt, m0_gnt});
            end
            if (prev_g >= 0) begin
                checks++;
                if (m0_oval !== (prev_g == 0) || m1_oval !== (prev_g == 1)
                    || ((prev_g == 0) ? m0_odat : m1_odat) !== exp_mem[prev_a]) begin
                    errors++;
                    $display("FAIL lock_oval cycle %0d: got {m1,m0}=%b%b data %h want owner %0d data %h",
                             k, m1_oval, m0_oval, bram_odat, prev_g, exp_mem[prev_a]);
                end
            end
            prev_g = (k < 4) ? 0 : ((k == 4) ? 1 : -1);
            if (prev_g >= 0) prev_a = addr_v[prev_g][7:0];
            next_cycle();
        end
    endtask

    task automatic test_last_tie();
        logic [1:0] exp_v [3];
        exp_v[0] = 2'b10;
        exp_v[1] = 2'b01;
        exp_v[2] = 2'b10;
        apply_reset(1);
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            set_port(1, 1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 255)), $urandom);
            if (k > 0) set_port(0, 1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 255)), $urandom);
            @(negedge clk);
            checks++;
            if ({m1_gnt, m0_gnt} !== exp_v[k]) begin
                errors++;
                $display("FAIL tie_last cycle %0d: got {m1,m0}=%b want %b", k, {m1_gnt, m0_gnt}, exp_v[k]);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_lock();
        apply_reset(1);
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            set_port(1, 1'b1, 1'b1, 1'b0, 32'($urandom_range(0, 255)), $urandom);
            if (k == 1) set_port(0, 1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 255)), $urandom);
            @(negedge clk);
            checks++;
            if ({m1_gnt, m0_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL lock1_grant cycle %0d: got {m1,m0}=%b want 10", k, {m1_gnt, m0_gnt});
            end
            next_cycle();
        end
        // read from m1 is in flight while reset is applied
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, bram_wren, bram_rden, m0_oval, m1_oval} !== 6'b000000) begin
                errors++;
                $display("FAIL midlock_reset_low cycle %0d: got %b want 000000", k,
                         {m0_gnt, m1_gnt, bram_wren, bram_rden, m0_oval, m1_oval});
            end
            next_cycle();
        end
        rst_n = 1'b1;
        set_port(0, 1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 255)), $urandom);
        set_port(1, 1'b1, 1'b1, 1'b0, 32'($urandom_range(0, 255)), $urandom);
        @(negedge clk);
        checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01 || {m1_oval, m0_oval} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_arb: got gnt{m1,m0}=%b oval{m1,m0}=%b want 01 00", {m1_gnt, m0_gnt}, {m1_oval, m0_oval});
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({m1_oval, m0_oval} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_oval: got {m1,m0}=%b want 01", {m1_oval, m0_oval});
        end
        next_cycle();
    endtask

    task automatic test_random();
        int lock_owner, last_idx, g, pend_who;
        logic pend_valid;
        logic [DW-1:0] pend_data;
        logic e_wr, e_rd, e_ov0, e_ov1;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_idat;
        apply_reset(1);
        lock_owner = -1;
        last_idx   = 1;
        pend_valid = 1'b0;
        pend_who   = 0;
        pend_data  = 32'h0;
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            for (int p = 0; p < 2; p++)
                set_port(p, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 35),
                         1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
            // who should get the port this cycle
            if (!rst_n) g = -1;
            else if (lock_owner >= 0) g = req_v[lock_owner] ? lock_owner : -1;
            else if (req_v[0] && req_v[1]) g = 1 - last_idx;
            else if (req_v[0]) g = 0;
            else if (req_v[1]) g = 1;
            else g = -1;
            e_wr = 1'b0;
            e_rd = 1'b0;
            if (g >= 0) begin
                e_wr = wren_v[g];
                e_rd = ~wren_v[g];
            end
            e_addr = (g == 1) ? addr_v[1] : addr_v[0];
            e_idat = (g == 1) ? idat_v[1] : idat_v[0];
            e_ov0 = rst_n && pend_valid && (pend_who == 0);
            e_ov1 = rst_n && pend_valid && (pend_who == 1);
            @(negedge clk);
            checks++;
            if (m0_gnt !== (g == 0) || m1_gnt !== (g == 1)) begin
                errors++;
                $display("FAIL rnd_grant cycle %0d: got {m1,m0}=%b%b want index %0d", n, m1_gnt, m0_gnt, g);
            end
            checks++;
            if (bram_wren !== e_wr || bram_rden !== e_rd) begin
                errors++;
                $display("FAIL rnd_strobe cycle %0d: got wren=%b rden=%b want %b %b", n, bram_wren, bram_rden, e_wr, e_rd);
            end
            checks++;
            if (bram_addr !== e_addr || bram_idat !== e_idat) begin
                errors++;
                $display("FAIL rnd_mux cycle %0d: got %h/%h want %h/%h", n, bram_addr, bram_idat, e_addr, e_idat);
            end
            checks++;
            if (m0_oval !== e_ov0 || m1_oval !== e_ov1) begin
                errors++;
                $display("FAIL rnd_oval cycle %0d: got {m1,m0}=%b%b want %b%b", n, m1_oval, m0_oval, e_ov1, e_ov0);
            end
            if (e_ov0 || e_ov1) begin
                checks++;
                if ((e_ov0 ? m0_odat : m1_odat) !== pend_data) begin
                    errors++;
                    $display("FAIL rnd_odat cycle %0d: got %h want %h", n, e_ov0 ? m0_odat : m1_odat, pend_data);
                end
            end
            // advance the reference model past this clock edge
            pend_valid = 1'b0;
            if (!rst_n) begin
                lock_owner = -1;
                last_idx   = 1;
            end else if (g < 0) begin
                lock_owner = -1;
            end else begin
                if (lock_owner < 0) begin
                    last_idx = g;
                    if (lock_v[g]) lock_owner = g;
                end else if (!lock_v[g]) begin
                    lock_owner = -1;
                end
                if (wren_v[g]) begin
                    exp_mem[addr_v[g][7:0]] = idat_v[g];
                end else begin
                    pend_valid = 1'b1;
                    pend_who   = g;
                    pend_data  = exp_mem[addr_v[g][7:0]];
                end
            end
            next_cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = 32'h5A00_0000 | i;
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        test_reset();
        test_round_robin();
        test_write_read();
        test_lock_burst();
        test_last_tie();
        test_reset_mid_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 32, data width of requester and BRAM-controller data buses.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width of requester and BRAM-controller address buses.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports m0_req / m1_req  input  1  requester wants an access this cycle.
REQ-006 SHALL have ports m0_lock / m1_lock  input  1  requester holds the port after the current grant (burst).
REQ-007 SHALL have ports m0_wren / m1_wren  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_addr / m1_addr  input  ADDR_WIDTH  access address.
REQ-009 SHALL have ports m0_idat / m1_idat  input  DAT_WIDTH  write data.
REQ-010 SHALL have ports m0_gnt / m1_gnt  output  1  access accepted this cycle (combinational).
REQ-011 SHALL have ports m0_odat / m1_odat  output  DAT_WIDTH  read data; both driven from bram_odat.
REQ-012 SHALL have ports m0_oval / m1_oval  output  1  read data valid for that requester.
REQ-013 SHALL have ports bram_addr, bram_idat  output  ADDR_WIDTH, DAT_WIDTH  to BRAM controller.
REQ-014 SHALL have ports bram_wren, bram_rden  output  1  write / read strobe to BRAM controller.
REQ-015 SHALL have ports bram_odat, bram_oval  input  DAT_WIDTH, 1  read data / valid from BRAM controller; oval arrives exactly 1 cycle after bram_rden.

Function
REQ-016 SHALL hold state ARB, LOCK0 or LOCK1, a round-robin pointer last (1 bit) and a read tag rd_tag (1 bit).
REQ-017 In ARB, exactly one req high SHALL grant that requester; both high SHALL grant the requester != last; none high SHALL grant none.
REQ-018 On any grant in ARB, last SHALL update to the granted index next cycle.
REQ-019 In ARB, grant to mX with mX_lock=1 SHALL move the state to LOCKX next cycle; otherwise the state stays ARB.
REQ-020 In LOCKX, only mX SHALL be granted (when mX_req=1); the other requester's req SHALL be ignored.
REQ-021 In LOCKX, mX_req=0 or mX_lock=0 SHALL return the state to ARB next cycle; a cycle with mX_req=1, mX_lock=0 is still granted (final beat).
REQ-022 last SHALL NOT change while in LOCKX.
REQ-023 At most one of m0_gnt, m1_gnt SHALL be high in any cycle.
REQ-024 bram_addr/bram_idat SHALL mux the granted requester's addr/idat; with no grant they SHALL carry m0_addr/m0_idat.
REQ-025 bram_wren SHALL equal gnt AND granted wren; bram_rden SHALL equal gnt AND NOT granted wren; both 0 with no grant.
REQ-026 Each bram_rden=1 cycle SHALL load rd_tag with the granted index.
REQ-027 mX_oval SHALL equal bram_oval AND (rd_tag == X); back-to-back reads from alternating requesters SHALL route each datum correctly.
REQ-028 Throughput SHALL be one access per cycle; no bubble on grant switch or lock entry/exit.
REQ-029 Write and read to the same address in consecutive cycles SHALL be issued in grant order; no reordering.

Reset
REQ-030 While rst_n=0, m0_gnt, m1_gnt, bram_wren, bram_rden, m0_oval, m1_oval SHALL be 0 regardless of inputs.
REQ-031 Reset SHALL set state=ARB, last=1 (m0 wins first tie), rd_tag=0.
REQ-032 Reset asserted mid-lock SHALL drop the lock; an outstanding read SHALL be discarded (no oval in the cycle after reset release).

Verification
REQ-033 Both req high, no lock, 4 cycles from reset, all reads -> grants m0,m1,m0,m1; bram_rden high every cycle; oval one cycle later to matching requester.
REQ-034 m1 write addr 0x10 data 0xA5A5A5A5, next cycle m0 read addr 0x10 -> m0_oval with m0_odat=0xA5A5A5A5 two cycles after the write; m1_oval stays 0.
REQ-035 m0 lock=1 for 3 beats, m1_req held high -> m0 granted 4 cycles (3 locked + final beat), m1 granted cycle 5 with no idle gap.
REQ-036 m1 req alone, then m1 and m0 both -> m1 granted, then m0 granted (last=1).
REQ-037 Reset pulsed during LOCK1 with read outstanding -> all gnt/oval 0 during reset; after release, state ARB, m0 wins tie, no stray m1_oval.
